aes_sideload_guard: RTL and testbench
=====================================

# aes_sideload_guard

Upstream guard on the key-manager → AES sideload path: registers each sideload key push from keymgr and forwards it one cycle later to `aes_core` `keymgr_key_i`. It tracks how often the same unmasked key is pushed back-to-back and blocks forwarding once a repetition threshold is hit. This cuts off repeated-key trigger sequences, such as the 257-push magic-key pattern, before they reach the core. It latches a sticky alert that feeds the fatal alert aggregation.

## Interface
Parameters:
- `KeyWidth`, 128, width of each key share
- `RepeatThresh`, 16, number of identical consecutive pushes after the first one that are still forwarded; the next identical push is blocked
- `IdleCycles`, 1024, number of consecutive cycles with no push after which repeat tracking is forgotten
- `CntW`, `$clog2(RepeatThresh+1)`, width of the repeat counter (derived)

Ports:
- `clk_i`  in  1  clock
- `rst_i`  in  1  reset, synchronous, active-high
- `key_valid_i`  in  1  single-cycle sideload push strobe from keymgr
- `key_share0_i`  in  KeyWidth  key share 0
- `key_share1_i`  in  KeyWidth  key share 1
- `clear_i`  in  1  software pulse that clears the blocked state, counters and alert
- `key_valid_o`  out  1  forwarded push strobe to aes_core
- `key_share0_o`  out  KeyWidth  forwarded share 0
- `key_share1_o`  out  KeyWidth  forwarded share 1
- `alert_o`  out  1  sticky; high while in BLOCKED
- `repeat_cnt_o`  out  CntW  current identical-repeat count
- `blocked_cnt_o`  out  16  number of pushes dropped since the last clear; saturates at 0xFFFF

## Operation
- Unmasked key `K = key_share0_i ^ key_share1_i`. Only `K` is compared. Shares are forwarded unmodified.
- Internal registers: `last_key` (KeyWidth), repeat counter, idle counter, blocked counter.
- FSM has three states: IDLE, TRACK, BLOCKED.
- IDLE:
  - On a push: forward it, set `last_key = K`, clear the repeat counter, go to TRACK.
- TRACK, on a push:
  - If `K != last_key`: forward it, set `last_key = K`, clear the repeat counter.
  - If `K == last_key` and repeat counter < RepeatThresh: forward it and increment the counter.
  - If `K == last_key` and repeat counter == RepeatThresh: drop the push, go to BLOCKED, increment `blocked_cnt`.
- TRACK, idle timeout:
  - The idle counter increments on every cycle without a push and clears on any push.
  - When it reaches IdleCycles: go to IDLE, clear the repeat counter and idle counter. `last_key` becomes don't-care.
- BLOCKED:
  - Every push is dropped, and `blocked_cnt` increments with saturation.
  - The idle timeout is inactive.
  - The only exits are `clear_i` and `rst_i`.
- `clear_i` (any state):
  - Go to IDLE, clear the repeat, idle and blocked counters.
  - It has priority over a push in the same cycle. That push is then handled as the first push from IDLE: it is forwarded and the next state is TRACK with count 0.
- An all-zero `K` is treated like any other key.
- The repeat counter never exceeds RepeatThresh and never wraps.

## Timing
- Reset values: `key_valid_o=0`, `key_share0_o=0`, `key_share1_o=0`, `alert_o=0`, `repeat_cnt_o=0`, `blocked_cnt_o=0`. Internally the state is IDLE and `last_key=0`.
- Forwarding latency is 1 cycle: a push at edge N appears on `key_valid_o` and the shares at N+1.
  - `key_valid_o` is a single-cycle pulse.
  - Output shares hold their last value when `key_valid_o` is low.
- A dropped push produces no `key_valid_o` pulse.
- `alert_o` is registered. It rises in the cycle after the blocking push and falls in the cycle after `clear_i`.
- `repeat_cnt_o` and `blocked_cnt_o` update in the cycle after the triggering push.
- Pushes on consecutive cycles are legal and each one is evaluated. There is no backpressure.
- `rst_i` asserted mid-sequence: at the next edge all registers return to their reset values. A push in the same cycle as reset is lost.

## Test plan
- Reset:
  - Stimulus: assert `rst_i` for 3 cycles with random inputs.
  - Required response: all outputs are 0, and the first push is forwarded 1 cycle later with identical shares.
- Threshold block (RepeatThresh=16):
  - Stimulus: 17 pushes with `K=DEADBEEF_AE5C0FFE_BADC0FFE_01234567`, 2 cycles apart.
  - Required response: 17 forwarded pulses, then `repeat_cnt_o=16`. The 18th push is dropped; `alert_o` goes to 1 and `blocked_cnt_o=1`.
- Trigger sequence:
  - Stimulus: 257 identical pushes of that key.
  - Required response: exactly 17 forwarded, `blocked_cnt_o=240`, `alert_o` stays 1. A following different key is also dropped (`blocked_cnt_o=241`).
- Alternation and masking:
  - Stimulus: alternate keys A and B for 100 pushes, then push A with shares (A^M, M) twice.
  - Required response: alternation never exceeds `repeat_cnt_o=0`. The masked A pushes count as A.
- Idle timeout (IdleCycles=1024):
  - Stimulus: 10 identical pushes, a 1024-cycle gap, then the same key.
  - Required response: after the gap `repeat_cnt_o=0`, and pushes resume from count 0. A 1023-cycle gap keeps the count instead.
- Clear:
  - Stimulus: in BLOCKED, assert `clear_i` together with a push.
  - Required response: the push is forwarded, `alert_o=0`, `blocked_cnt_o=0`, `repeat_cnt_o=0`, and the state is TRACK.

Source files
------------

// File: rtl/aes_sideload_guard.sv
// Sideload key guard between keymgr and aes_core: forwards key pushes one cycle
// later and blocks forwarding once the same unmasked key repeats too often.
module aes_sideload_guard #(
  parameter int KeyWidth     = 128,
  parameter int RepeatThresh = 16,
  parameter int IdleCycles   = 1024,
  parameter int CntW         = $clog2(RepeatThresh + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                key_valid_i,
  input  logic [KeyWidth-1:0] key_share0_i,
  input  logic [KeyWidth-1:0] key_share1_i,
  input  logic                clear_i,
  output logic                key_valid_o,
  output logic [KeyWidth-1:0] key_share0_o,
  output logic [KeyWidth-1:0] key_share1_o,
  output logic                alert_o,
  output logic [CntW-1:0]     repeat_cnt_o,
  output logic [15:0]         blocked_cnt_o
);

  localparam int IdleW = $clog2(IdleCycles + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TRACK   = 2'd1,
    BLOCKED = 2'd2
  } state_e;

  state_e              state_r;
  logic [KeyWidth-1:0] last_key_r;
  logic [IdleW-1:0]    idle_cnt_r;
  logic [KeyWidth-1:0] key_s;
  logic                match_s;
  logic                rep_full_s;
  logic                idle_done_s;
  logic                blk_sat_s;

  assign key_s       = key_share0_i ^ key_share1_i;
  assign match_s     = (key_s == last_key_r);
  assign rep_full_s  = (repeat_cnt_o == CntW'(RepeatThresh));
  assign idle_done_s = (idle_cnt_r == IdleW'(IdleCycles - 1));
  assign blk_sat_s   = (blocked_cnt_o == 16'hFFFF);

  // Guard FSM with registered forwarding path, counters and sticky alert.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r       <= IDLE;
      last_key_r    <= '0;
      idle_cnt_r    <= '0;
      key_valid_o   <= 1'b0;
      key_share0_o  <= '0;
      key_share1_o  <= '0;
      alert_o       <= 1'b0;
      repeat_cnt_o  <= '0;
      blocked_cnt_o <= 16'h0000;
    end else begin
      key_valid_o <= 1'b0;
      if (clear_i) begin
        // A push coincident with clear is handled as the first push from IDLE.
        alert_o       <= 1'b0;
        repeat_cnt_o  <= '0;
        idle_cnt_r    <= '0;
        blocked_cnt_o <= 16'h0000;
        if (key_valid_i) begin
          key_valid_o  <= 1'b1;
          key_share0_o <= key_share0_i;
          key_share1_o <= key_share1_i;
          last_key_r   <= key_s;
          state_r      <= TRACK;
        end else begin
          state_r <= IDLE;
        end
      end else begin
        case (state_r)
          IDLE: begin
            if (key_valid_i) begin
              key_valid_o  <= 1'b1;
              key_share0_o <= key_share0_i;
              key_share1_o <= key_share1_i;
              last_key_r   <= key_s;
              repeat_cnt_o <= '0;
              idle_cnt_r   <= '0;
              state_r      <= TRACK;
            end else begin
              state_r <= IDLE;
            end
          end
          TRACK: begin
            if (key_valid_i) begin
              idle_cnt_r <= '0;
              if (!match_s) begin
                key_valid_o  <= 1'b1;
                key_share0_o <= key_share0_i;
                key_share1_o <= key_share1_i;
                last_key_r   <= key_s;
                repeat_cnt_o <= '0;
              end else if (!rep_full_s) begin
                key_valid_o  <= 1'b1;
                key_share0_o <= key_share0_i;
                key_share1_o <= key_share1_i;
                repeat_cnt_o <= repeat_cnt_o + CntW'(1);
              end else begin
                state_r <= BLOCKED;
                alert_o <= 1'b1;
                if (!blk_sat_s) begin
                  blocked_cnt_o <= blocked_cnt_o + 16'd1;
                end else begin
                  blocked_cnt_o <= blocked_cnt_o;
                end
              end
            end else if (idle_done_s) begin
              // Long silence: forget the repeat history.
              state_r      <= IDLE;
              repeat_cnt_o <= '0;
              idle_cnt_r   <= '0;
            end else begin
              idle_cnt_r <= idle_cnt_r + IdleW'(1);
            end
          end
          BLOCKED: begin
            alert_o <= 1'b1;
            if (key_valid_i && !blk_sat_s) begin
              blocked_cnt_o <= blocked_cnt_o + 16'd1;
            end else begin
              blocked_cnt_o <= blocked_cnt_o;
            end
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aes_sideload_guard.sv
// Directed self-checking bench for aes_sideload_guard (default parameters).
module tb_aes_sideload_guard;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         key_valid_i = 1'b0;
  logic [127:0] key_share0_i = '0;
  logic [127:0] key_share1_i = '0;
  logic         clear_i = 1'b0;
  logic         key_valid_o;
  logic [127:0] key_share0_o;
  logic [127:0] key_share1_o;
  logic         alert_o;
  logic [4:0]   repeat_cnt_o;
  logic [15:0]  blocked_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [127:0] KEY_M = 128'hDEADBEEF_AE5C0FFE_BADC0FFE_01234567;
  localparam logic [127:0] KEY_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] KEY_B = 128'hFFEEDDCC_BBAA9988_77665544_33221100;
  localparam logic [127:0] KEY_C = 128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0;

  aes_sideload_guard dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .key_valid_i  (key_valid_i),
    .key_share0_i (key_share0_i),
    .key_share1_i (key_share1_i),
    .clear_i      (clear_i),
    .key_valid_o  (key_valid_o),
    .key_share0_o (key_share0_o),
    .key_share1_o (key_share1_o),
    .alert_o      (alert_o),
    .repeat_cnt_o (repeat_cnt_o),
    .blocked_cnt_o(blocked_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #5ms;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic apply_reset();
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  // One push in the next cycle; fwd reports whether it was forwarded.
  task automatic push(input logic [127:0] s0, input logic [127:0] s1,
                      input logic clr, output logic fwd);
    key_valid_i  = 1'b1;
    key_share0_i = s0;
    key_share1_i = s1;
    clear_i      = clr;
    @(posedge clk_i); #1;
    fwd          = key_valid_o;
    key_valid_i  = 1'b0;
    clear_i      = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    logic fwd;
    logic [127:0] s0, s1;
    rst_i = 1'b1;
    repeat (3) begin
      key_valid_i  = 1'($urandom());
      key_share0_i = rnd128();
      key_share1_i = rnd128();
      clear_i      = 1'($urandom());
      @(posedge clk_i); #1;
    end
    rst_i = 1'b0; key_valid_i = 1'b0; clear_i = 1'b0;
    n_cmp++;
    if ({key_valid_o, alert_o, repeat_cnt_o, blocked_cnt_o} !== 23'd0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got v=%b a=%b r=%0d b=%0d, need all 0",
               key_valid_o, alert_o, repeat_cnt_o, blocked_cnt_o);
    end
    n_cmp++;
    if ({key_share0_o, key_share1_o} !== 256'd0) begin
      n_bad++;
      $display("FAIL reset_shares: got %h %h, need 0", key_share0_o, key_share1_o);
    end
    s0 = rnd128(); s1 = rnd128();
    push(s0, s1, 1'b0, fwd);
    n_cmp++;
    if ({fwd, key_share0_o, key_share1_o} !== {1'b1, s0, s1}) begin
      n_bad++;
      $display("FAIL reset_first_push: got v=%b %h %h, need v=1 %h %h",
               fwd, key_share0_o, key_share1_o, s0, s1);
    end
    idle_cycles(1);
    n_cmp++;
    if ({key_valid_o, key_share0_o, key_share1_o} !== {1'b0, s0, s1}) begin
      n_bad++;
      $display("FAIL pulse_hold: got v=%b %h %h, need v=0 %h %h",
               key_valid_o, key_share0_o, key_share1_o, s0, s1);
    end
  endtask

  task automatic test_threshold();
    logic fwd;
    logic [127:0] m;
    int nfwd = 0;
    apply_reset();
    for (int i = 0; i < 17; i++) begin
      m = rnd128();
      push(KEY_M ^ m, m, 1'b0, fwd);
      if (fwd) nfwd++;
      idle_cycles(1);
    end
    n_cmp++;
    if (nfwd !== 17 || repeat_cnt_o !== 5'd16) begin
      n_bad++;
      $display("FAIL thresh_fwd: got fwd=%0d rep=%0d, need fwd=17 rep=16", nfwd, repeat_cnt_o);
    end
    n_cmp++;
    if (alert_o !== 1'b0) begin
      n_bad++;
      $display("FAIL thresh_no_alert: got alert=%b, need 0", alert_o);
    end
    push(KEY_M, 128'd0, 1'b0, fwd);
    n_cmp++;
    if ({fwd, alert_o, blocked_cnt_o, repeat_cnt_o} !== {1'b0, 1'b1, 16'd1, 5'd16}) begin
      n_bad++;
      $display("FAIL thresh_block: got v=%b a=%b b=%0d r=%0d, need v=0 a=1 b=1 r=16",
               fwd, alert_o, blocked_cnt_o, repeat_cnt_o);
    end
  endtask

  task automatic test_back_to_back();
    logic fwd;
    int nfwd = 0;
    apply_reset();
    for (int i = 0; i < 257; i++) begin
      push(KEY_M, 128'd0, 1'b0, fwd);
      if (fwd) nfwd++;
    end
    n_cmp++;
    if (nfwd !== 17 || blocked_cnt_o !== 16'd240 || alert_o !== 1'b1) begin
      n_bad++;
      $display("FAIL trigger_seq: got fwd=%0d b=%0d a=%b, need fwd=17 b=240 a=1",
               nfwd, blocked_cnt_o, alert_o);
    end
    idle_cycles(1100);
    push(KEY_C, 128'd0, 1'b0, fwd);
    n_cmp++;
    if ({fwd, blocked_cnt_o, alert_o} !== {1'b0, 16'd241, 1'b1}) begin
      n_bad++;
      $display("FAIL blocked_other_key: got v=%b b=%0d a=%b, need v=0 b=241 a=1",
               fwd, blocked_cnt_o, alert_o);
    end
  endtask

  task automatic test_alternation();
    logic fwd;
    logic [127:0] m;
    int nfwd = 0;
    int max_rep = 0;
    apply_reset();
    for (int i = 0; i < 100; i++) begin
      push((i % 2 == 0) ? KEY_A : KEY_B, 128'd0, 1'b0, fwd);
      if (fwd) nfwd++;
      if (int'(repeat_cnt_o) > max_rep) max_rep = int'(repeat_cnt_o);
    end
    n_cmp++;
    if (nfwd !== 100 || max_rep !== 0) begin
      n_bad++;
      $display("FAIL alternation: got fwd=%0d max_rep=%0d, need 100 and 0", nfwd, max_rep);
    end
    m = rnd128();
    push(KEY_A ^ m, m, 1'b0, fwd);
    m = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C;
    push(KEY_A ^ m, m, 1'b0, fwd);
    n_cmp++;
    if ({fwd, repeat_cnt_o, key_share0_o, key_share1_o} !== {1'b1, 5'd1, KEY_A ^ m, m}) begin
      n_bad++;
      $display("FAIL masked_repeat: got v=%b r=%0d %h %h, need v=1 r=1 %h %h",
               fwd, repeat_cnt_o, key_share0_o, key_share1_o, KEY_A ^ m, m);
    end
  endtask

  task automatic test_idle_timeout();
    logic fwd;
    apply_reset();
    for (int i = 0; i < 10; i++) push(128'd0, 128'd0, 1'b0, fwd);
    n_cmp++;
    if (repeat_cnt_o !== 5'd9) begin
      n_bad++;
      $display("FAIL zero_key_count: got rep=%0d, need 9", repeat_cnt_o);
    end
    idle_cycles(1024);
    n_cmp++;
    if (repeat_cnt_o !== 5'd0) begin
      n_bad++;
      $display("FAIL idle_1024_clear: got rep=%0d, need 0", repeat_cnt_o);
    end
    push(128'd0, 128'd0, 1'b0, fwd);
    n_cmp++;
    if ({fwd, repeat_cnt_o} !== {1'b1, 5'd0}) begin
      n_bad++;
      $display("FAIL idle_resume: got v=%b rep=%0d, need v=1 rep=0", fwd, repeat_cnt_o);
    end
    push(128'd0, 128'd0, 1'b0, fwd);
    idle_cycles(1023);
    push(128'd0, 128'd0, 1'b0, fwd);
    n_cmp++;
    if ({fwd, repeat_cnt_o} !== {1'b1, 5'd2}) begin
      n_bad++;
      $display("FAIL idle_1023_keep: got v=%b rep=%0d, need v=1 rep=2", fwd, repeat_cnt_o);
    end
  endtask

  task automatic test_clear();
    logic fwd;
    apply_reset();
    for (int i = 0; i < 19; i++) push(KEY_M, 128'd0, 1'b0, fwd);
    n_cmp++;
    if ({alert_o, blocked_cnt_o} !== {1'b1, 16'd2}) begin
      n_bad++;
      $display("FAIL pre_clear: got a=%b b=%0d, need a=1 b=2", alert_o, blocked_cnt_o);
    end
    push(KEY_C, KEY_A, 1'b1, fwd);
    n_cmp++;
    if ({fwd, alert_o, blocked_cnt_o, repeat_cnt_o, key_share0_o, key_share1_o} !==
        {1'b1, 1'b0, 16'd0, 5'd0, KEY_C, KEY_A}) begin
      n_bad++;
      $display("FAIL clear_push: got v=%b a=%b b=%0d r=%0d, need v=1 a=0 b=0 r=0",
               fwd, alert_o, blocked_cnt_o, repeat_cnt_o);
    end
    push(KEY_C ^ KEY_A, 128'd0, 1'b0, fwd);
    n_cmp++;
    if ({fwd, repeat_cnt_o} !== {1'b1, 5'd1}) begin
      n_bad++;
      $display("FAIL clear_track: got v=%b rep=%0d, need v=1 rep=1", fwd, repeat_cnt_o);
    end
    rst_i = 1'b1;
    push(KEY_B, 128'd0, 1'b0, fwd);
    rst_i = 1'b0;
    n_cmp++;
    if ({fwd, repeat_cnt_o, key_share0_o} !== {1'b0, 5'd0, 128'd0}) begin
      n_bad++;
      $display("FAIL reset_mid_seq: got v=%b rep=%0d s0=%h, need 0 0 0",
               fwd, repeat_cnt_o, key_share0_o);
    end
  endtask

  initial begin
    test_reset();
    test_threshold();
    test_back_to_back();
    test_alternation();
    test_idle_timeout();
    test_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
